// File: rtl/pll_phase_arbiter.sv
// pll_phase_arbiter: round-robin owner of the PLL dynamic phase-shift port.
// Each granted request is a relative move of N steps on one counter; every
// step is sequenced at scanclk cadence and acknowledged by phasedone.
//
// Optional feature macro: PLL_PHASE_POS_EN (adds the phase_pos tracker/port).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req/req_dir           per-requester request level and direction (1=up)
//   req_cnt/req_sel       per-requester step count (8b) and counter select (3b)
//   grant                 one-hot, acceptance through finish
//   done/err              1-cycle completion pulse; err flags a timeout abort
//   busy                  high whenever the sequencer is not idle
//   phase_done            PLL phasedone (already synchronised)
//   phasecounterselect, phaseupdown, phasestep, scanclk   PLL phase port
//   phase_pos             tracked C-counter position (feature builds only)
module pll_phase_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned STEP_TMO    = 100,
  parameter int unsigned PHASE_STEPS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_dir,
  input  logic [8*NREQ-1:0] req_cnt,
  input  logic [3*NREQ-1:0] req_sel,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  input  logic              phase_done,
  output logic [2:0]        phasecounterselect,
  output logic              phaseupdown,
  output logic              phasestep,
  output logic              scanclk
`ifdef PLL_PHASE_POS_EN
  ,
  output logic [7:0]        phase_pos
`endif
);

  localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DW      = $clog2(SCAN_DIV);
  localparam int unsigned TMO_CYC = 2 * SCAN_DIV * STEP_TMO;
  // Two scanclk periods from phasestep falling to the next step.
  localparam int unsigned GAP_CYC = 4 * SCAN_DIV;
  localparam int unsigned MAX_CYC = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, ASSERT, HOLD, WAITDONE, NEXT, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [7:0]      rem_q, rem_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      rise_q, rise_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            seen_q, seen_d;
  logic            abort_q, abort_d;
  logic            pd_q;

  logic [NREQ-1:0] grant_d, done_d;
  logic            err_d, busy_d;
  logic [2:0]      pcs_d;
  logic            pud_d, ps_d, sc_d;

  logic            found;
  logic [IW-1:0]   pick, cand;
  logic            div_wrap, pd_rise, got;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    rem_d    = rem_q;
    div_d    = div_q;
    rise_d   = rise_q;
    tmo_d    = tmo_q;
    seen_d   = seen_q;
    abort_d  = abort_q;
    grant_d  = grant;
    done_d   = '0;
    err_d    = 1'b0;
    pcs_d    = phasecounterselect;
    pud_d    = phaseupdown;
    ps_d     = phasestep;
    sc_d     = scanclk;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    got      = 1'b0;
    div_wrap = (div_q == DW'(SCAN_DIV - 1));
    pd_rise  = phase_done & ~pd_q;

    unique case (state_q)
      IDLE: begin
        // First active requester after the pointer wins.
        for (int unsigned k = 1; k <= NREQ; k++) begin
          cand = IW'((32'(ptr_q) + k) % NREQ);
          if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = LATCH;
        end
      end

      LATCH: begin
        rem_d   = req_cnt[8*gidx_q +: 8];
        pcs_d   = req_sel[3*gidx_q +: 3];
        pud_d   = req_dir[gidx_q];
        abort_d = 1'b0;
        state_d = (req_cnt[8*gidx_q +: 8] == 8'd0) ? FINISH : ASSERT;
      end

      ASSERT: begin
        ps_d    = 1'b1;
        sc_d    = 1'b0;
        div_d   = '0;
        rise_d  = '0;
        state_d = HOLD;
      end

      HOLD: begin
        // phasestep spans two scanclk rises and drops on the next fall.
        div_d = div_wrap ? '0 : div_q + DW'(1);
        if (div_wrap) begin
          sc_d = ~scanclk;
          if (!scanclk) begin
            rise_d = rise_q + 2'd1;
          end else if (rise_q == 2'd2) begin
            ps_d    = 1'b0;
            tmo_d   = '0;
            seen_d  = 1'b0;
            state_d = WAITDONE;
          end
        end
      end

      WAITDONE: begin
        div_d = div_wrap ? '0 : div_q + DW'(1);
        if (div_wrap) begin
          sc_d = ~scanclk;
        end
        got    = seen_q | pd_rise;
        seen_d = got;
        // An early phasedone is remembered until the minimum step gap elapses.
        if (got && (tmo_q >= TW'(GAP_CYC - 1))) begin
          state_d = NEXT;
        end else if (!got && (tmo_q == TW'(TMO_CYC - 1))) begin
          abort_d = 1'b1;
          sc_d    = 1'b0;
          state_d = FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      NEXT: begin
        rem_d   = rem_q - 8'd1;
        sc_d    = 1'b0;
        div_d   = '0;
        state_d = (rem_q == 8'd1) ? FINISH : ASSERT;
      end

      FINISH: begin
        done_d[gidx_q] = 1'b1;
        err_d          = abort_q;
        grant_d        = '0;
        ptr_d          = gidx_q;
        ps_d           = 1'b0;
        sc_d           = 1'b0;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      ptr_q              <= '0;
      gidx_q             <= '0;
      rem_q              <= '0;
      div_q              <= '0;
      rise_q             <= '0;
      tmo_q              <= '0;
      seen_q             <= 1'b0;
      abort_q            <= 1'b0;
      pd_q               <= 1'b0;
      grant              <= '0;
      done               <= '0;
      err                <= 1'b0;
      busy               <= 1'b0;
      phasecounterselect <= 3'b010;
      phaseupdown        <= 1'b1;
      phasestep          <= 1'b0;
      scanclk            <= 1'b0;
    end else begin
      state_q            <= state_d;
      ptr_q              <= ptr_d;
      gidx_q             <= gidx_d;
      rem_q              <= rem_d;
      div_q              <= div_d;
      rise_q             <= rise_d;
      tmo_q              <= tmo_d;
      seen_q             <= seen_d;
      abort_q            <= abort_d;
      pd_q               <= phase_done;
      grant              <= grant_d;
      done               <= done_d;
      err                <= err_d;
      busy               <= busy_d;
      phasecounterselect <= pcs_d;
      phaseupdown        <= pud_d;
      phasestep          <= ps_d;
      scanclk            <= sc_d;
    end
  end

`ifdef PLL_PHASE_POS_EN
  logic [7:0] pos_d;

  // Completed steps on C-counter selects move the tracked position, wrapping.
  always_comb begin
    pos_d = phase_pos;
    if ((state_q == NEXT) &&
        ((phasecounterselect == 3'b000) || (phasecounterselect == 3'b010))) begin
      if (phaseupdown) begin
        pos_d = (phase_pos == 8'(PHASE_STEPS - 1)) ? 8'd0 : phase_pos + 8'd1;
      end else begin
        pos_d = (phase_pos == 8'd0) ? 8'(PHASE_STEPS - 1) : phase_pos - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_pos <= '0;
    end else begin
      phase_pos <= pos_d;
    end
  end
`else
  // Rotation size only matters to the position tracker.
  logic unused_phase_steps;
  assign unused_phase_steps = ^32'(PHASE_STEPS);
`endif

endmodule
